// File: rtl/psram_pkg.sv
// psram_pkg: command codes, responder FSM states and transfer direction for the QPI PSRAM responder
package psram_pkg;
  localparam logic [7:0] CMD_ENTER_QPI = 8'h35;
  localparam logic [7:0] CMD_QREAD = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  typedef enum logic [2:0] {IDLE, SPI_CMD, QPI_CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA, IGNORE} resp_state_t;
  typedef enum logic {DIR_RD, DIR_WR} dir_t;
  function automatic logic lanes_differ(input logic [7:0] d);
    return d[7:4] != d[3:0];
  endfunction
endpackage

// File: rtl/psram_resp_mem.sv
// psram_resp_mem: 2**ADDR_W x 16 synchronous single-port RAM, one-cycle read latency
module psram_resp_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);
  logic [15:0] mem [2**ADDR_W];
  always_ff @(posedge i_clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: dual x4 QPI PSRAM stand-in (35h/EBh/38h); PSRAM_RESP_LANE_CHECK_EN enables lane-mismatch error
module psram_qpi_responder
  import psram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_psram_csn,
  input  logic       i_psram_sclk_en,
  input  logic [7:0] i_psram_data,
  output logic [7:0] o_psram_data,
  output logic [7:0] o_psram_oe,
  output logic       o_qpi_mode,
  output logic       o_err,
  output logic [2:0] o_state
);
  localparam logic [7:0] K_LAST = 8'(7 + WAIT_CYCLES);
  resp_state_t state, es, nxt;
  dir_t dir;
  logic q, ph, set_qpi, mem_en, mem_we;
  logic [7:0] k, hi, nxt_data, nxt_oe, cmd_spi, cmd_qpi;
  logic [6:0] sh;
  logic [3:0] nib;
  logic [ADDR_W-1:0] wa, mem_addr;
  logic [15:0] rdata;
  assign q = !i_psram_csn && i_psram_sclk_en;
  assign nib = i_psram_data[3:0];
  // a qualified cycle seen in IDLE is handled directly as k=0 of the command phase
  assign es = state == IDLE ? (o_qpi_mode ? QPI_CMD : SPI_CMD) : state;
  assign cmd_spi = {sh, i_psram_data[0]};
  assign cmd_qpi = {sh[3:0], nib};
  assign o_state = state;
  always_ff @(posedge i_clk)
    if (i_rst || i_psram_csn) begin
      state <= IDLE;
      k <= '0;
    end else if (q) begin
      state <= nxt;
      k <= k + {7'd0, k != 8'hFF};
    end
  always_comb begin
    nxt = es;
    case (es)
      SPI_CMD: nxt = k > 8'd7 || (k == 8'd7 && cmd_spi != CMD_ENTER_QPI) ? IGNORE : SPI_CMD;
      QPI_CMD: nxt = k == 8'd0 ? QPI_CMD : cmd_qpi == CMD_QREAD || cmd_qpi == CMD_QWRITE ? ADDR : IGNORE;
      ADDR:    nxt = k == 8'd7 ? (dir == DIR_WR ? WR_DATA : RD_WAIT) : ADDR;
      RD_WAIT: nxt = k == K_LAST ? RD_DATA : RD_WAIT;
      default: nxt = es;
    endcase
  end
  // the next burst word is fetched on the low-byte beat; rdata still holds the current word that edge
  always_comb begin
    set_qpi = es == SPI_CMD && k == 8'd7 && cmd_spi == CMD_ENTER_QPI;
    mem_we = es == WR_DATA && ph;
    mem_en = q && !i_rst && (mem_we || (es == RD_WAIT && k == 8'd8) || (es == RD_DATA && ph));
    mem_addr = es == RD_DATA ? wa + 1'b1 : wa;
    nxt_oe = es == RD_DATA ? 8'hFF : 8'h00;
    nxt_data = es == RD_DATA ? (ph ? rdata[7:0] : rdata[15:8]) : o_psram_data;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_psram_data <= '0;
      o_psram_oe <= '0;
      o_qpi_mode <= 1'b0;
      ph <= 1'b0;
    end else if (i_psram_csn) begin
      o_psram_oe <= '0;
      ph <= 1'b0;
    end else if (q) begin
      o_psram_data <= nxt_data;
      o_psram_oe <= nxt_oe;
      sh <= es == SPI_CMD ? {sh[5:0], i_psram_data[0]} : {sh[2:0], nib};
      if (set_qpi) o_qpi_mode <= 1'b1;
      if (es == QPI_CMD && k == 8'd1) dir <= cmd_qpi == CMD_QWRITE ? DIR_WR : DIR_RD;
      if (es == ADDR) wa <= ADDR_W'({wa, nib});
      if (es == WR_DATA && !ph) hi <= i_psram_data;
      if (es == WR_DATA || es == RD_DATA) ph <= !ph;
      if ((es == WR_DATA || es == RD_DATA) && ph) wa <= wa + 1'b1;
    end
`ifdef PSRAM_RESP_LANE_CHECK_EN
  logic err, bad_cmd;
  assign bad_cmd = es == QPI_CMD && k == 8'd1 && cmd_qpi != CMD_QREAD && cmd_qpi != CMD_QWRITE && cmd_qpi != CMD_ENTER_QPI;
  always_ff @(posedge i_clk)
    if (i_rst) err <= 1'b0;
    else if (q && (bad_cmd || ((es == QPI_CMD || es == ADDR) && lanes_differ(i_psram_data)))) err <= 1'b1;
  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif
  psram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .i_clk(i_clk),
    .en(mem_en),
    .we(mem_we),
    .addr(mem_addr),
    .wdata({hi, i_psram_data}),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb_psram_qpi_responder: directed and randomized transactions checked against a word-array memory model
module tb_psram_qpi_responder;
  import psram_pkg::*;
  localparam int AW = 10, WC = 6, N = 1 << AW;
`ifdef PSRAM_RESP_LANE_CHECK_EN
  localparam logic LC = 1'b1;
`else
  localparam logic LC = 1'b0;
`endif
  logic i_clk = 1'b0, i_rst = 1'b1, i_psram_csn = 1'b1, i_psram_sclk_en = 1'b0;
  logic [7:0] i_psram_data = '0;
  logic [7:0] o_psram_data, o_psram_oe;
  logic o_qpi_mode, o_err;
  logic [2:0] o_state;
  logic [15:0] model [N];
  logic [15:0] wq[$];
  int passed = 0, total = 0;
  logic any_oe;
  psram_qpi_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_psram_csn(i_psram_csn), .i_psram_sclk_en(i_psram_sclk_en),
    .i_psram_data(i_psram_data), .o_psram_data(o_psram_data), .o_psram_oe(o_psram_oe),
    .o_qpi_mode(o_qpi_mode), .o_err(o_err), .o_state(o_state)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick(input logic [7:0] d);
    i_psram_csn = 1'b0;
    i_psram_sclk_en = 1'b1;
    i_psram_data = d;
    @(posedge i_clk);
    #1;
  endtask
  task automatic stall();
    i_psram_sclk_en = 1'b0;
    i_psram_data = 8'($urandom);
    @(posedge i_clk);
    #1;
    i_psram_sclk_en = 1'b1;
  endtask
  task automatic end_xfer();
    i_psram_csn = 1'b1;
    i_psram_sclk_en = 1'b0;
    @(posedge i_clk);
    #1;
  endtask
  task automatic do_reset();
    i_rst = 1'b1;
    i_psram_csn = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask
  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick({3'b0, b[i], 3'b0, b[i]});
    end_xfer();
  endtask
  task automatic qpi_hdr(input logic [7:0] cmd, input logic [23:0] a);
    tick({2{cmd[7:4]}});
    tick({2{cmd[3:0]}});
    for (int i = 5; i >= 0; i--) tick({2{a[i*4+:4]}});
  endtask
  task automatic write_burst(input logic [23:0] a);
    qpi_hdr(CMD_QWRITE, a);
    foreach (wq[i]) begin
      tick(wq[i][15:8]);
      if ($urandom_range(0, 4) == 0) stall();
      tick(wq[i][7:0]);
      model[(int'(a[AW-1:0]) + i) % N] = wq[i];
    end
    end_xfer();
    check("wr_end_oe", {8'd0, o_psram_oe}, 16'h0);
  endtask
  task automatic read_burst(input logic [23:0] a, input int n);
    logic [15:0] w;
    qpi_hdr(CMD_QREAD, a);
    any_oe = 1'b0;
    for (int i = 0; i < WC; i++) begin
      tick(8'($urandom));
      any_oe = any_oe | (|o_psram_oe);
    end
    check("rd_wait_oe", {15'd0, any_oe}, 16'h0);
    for (int i = 0; i < n; i++) begin
      w = model[(int'(a[AW-1:0]) + i) % N];
      tick(8'($urandom));
      check("rd_oe", {8'd0, o_psram_oe}, 16'h00FF);
      check("rd_hi", {8'd0, o_psram_data}, {8'd0, w[15:8]});
      if (i == 0) check("rd_state", {13'd0, o_state}, {13'd0, 3'(RD_DATA)});
      if ($urandom_range(0, 3) == 0) begin
        stall();
        check("stall_hold", {8'd0, o_psram_data}, {8'd0, w[15:8]});
      end
      tick(8'($urandom));
      check("rd_lo", {8'd0, o_psram_data}, {8'd0, w[7:0]});
    end
    end_xfer();
    check("rd_end_oe", {8'd0, o_psram_oe}, 16'h0);
  endtask
  initial begin
    do_reset();
    check("rst_data", {8'd0, o_psram_data}, 16'h0);
    check("rst_oe", {8'd0, o_psram_oe}, 16'h0);
    check("rst_qpi", {15'd0, o_qpi_mode}, 16'h0);
    check("rst_err", {15'd0, o_err}, 16'h0);
    check("rst_state", {13'd0, o_state}, {13'd0, 3'(IDLE)});
    spi_byte(CMD_ENTER_QPI);
    check("enter_qpi", {15'd0, o_qpi_mode}, 16'h1);
    check("enter_oe", {8'd0, o_psram_oe}, 16'h0);
    do_reset();
    spi_byte(8'h9F);
    check("spi_9f_qpi", {15'd0, o_qpi_mode}, 16'h0);
    qpi_hdr(CMD_QREAD, 24'h000123);
    any_oe = 1'b0;
    for (int i = 0; i < WC + 4; i++) begin
      tick(8'($urandom));
      any_oe = any_oe | (|o_psram_oe);
    end
    check("ignored_rd_oe", {15'd0, any_oe}, 16'h0);
    check("ignore_state", {13'd0, o_state}, {13'd0, 3'(IGNORE)});
    end_xfer();
    spi_byte(CMD_ENTER_QPI);
    check("reenter_qpi", {15'd0, o_qpi_mode}, 16'h1);
    wq = '{16'hA55A};
    write_burst(24'h000123);
    read_burst(24'h000123, 1);
    wq = '{16'h1111, 16'h2222};
    write_burst(24'h0003FF);
    read_burst(24'h0003FF, 2);
    read_burst(24'h000000, 1);
    qpi_hdr(CMD_QWRITE, 24'h000123);
    tick(8'h77);
    end_xfer();
    read_burst(24'h000123, 1);
    tick(8'hEE);
    tick(8'hBB);
    tick(8'h00);
    tick(8'h00);
    tick(8'h00);
    tick(8'h73);
    tick(8'h00);
    tick(8'h00);
    for (int i = 0; i < WC + 2; i++) tick(8'h00);
    end_xfer();
    check("lane_err", {15'd0, o_err}, {15'd0, LC});
    wq = '{16'h0F0F};
    write_burst(24'h000010);
    check("lane_err_sticky", {15'd0, o_err}, {15'd0, LC});
    qpi_hdr(CMD_QREAD, 24'h000010);
    for (int i = 0; i < WC + 1; i++) tick(8'h00);
    check("pre_rst_oe", {8'd0, o_psram_oe}, 16'h00FF);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("midrd_rst_oe", {8'd0, o_psram_oe}, 16'h0);
    check("midrd_rst_qpi", {15'd0, o_qpi_mode}, 16'h0);
    check("midrd_rst_state", {13'd0, o_state}, {13'd0, 3'(IDLE)});
    check("midrd_rst_err", {15'd0, o_err}, 16'h0);
    i_rst = 1'b0;
    end_xfer();
    spi_byte(CMD_ENTER_QPI);
    wq.delete();
    for (int i = 0; i < N; i++) wq.push_back(16'($urandom));
    write_burst(24'($urandom));
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        wq.delete();
        for (int i = 0; i < $urandom_range(1, 8); i++) wq.push_back(16'($urandom));
        write_burst(24'($urandom));
      end else read_burst(24'($urandom), $urandom_range(1, 8));
    end
    read_burst(24'h0003FC, 8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
